// File: rtl/debug_bus_pkg.sv
// Shared types and constants for the debug bus responder and the debug master.
package debug_bus_pkg;

    localparam int DBG_ADDR_W = 24;
    localparam int DBG_DATA_W = 8;
    localparam int LAT_CNT_W  = 3;

    // Command codes carried by the debug master's link
    localparam logic [1:0] CMD_READ   = 2'd0;
    localparam logic [1:0] CMD_WRITE  = 2'd1;
    localparam logic [1:0] CMD_HALT   = 2'd2;
    localparam logic [1:0] CMD_RESUME = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STALL,
        S_ISSUE,
        S_WAIT,
        S_ACK
    } state_t;

endpackage

// File: rtl/debug_halt_ctrl.sv
// Instruction-boundary halt flag; optional single-step when DBG_SINGLE_STEP_EN is defined.
// Halt sets on the sync+en edge of a pending request; release lands two edges after the request drops.
module debug_halt_ctrl (
    input  logic clk,
    input  logic rst,
    input  logic cpu_halt_req,
    input  logic cpu_sync,
    input  logic cpu_en,
`ifdef DBG_SINGLE_STEP_EN
    input  logic cpu_step_req,
`endif
    output logic cpu_halted
);

    logic halt_req_q;
    logic boundary;

    assign boundary = cpu_halt_req && cpu_sync && cpu_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt_req_q <= 1'b0;
            cpu_halted <= 1'b0;
        end else begin
            halt_req_q <= cpu_halt_req;
`ifdef DBG_SINGLE_STEP_EN
            // A step releases the core; the still-pending halt request re-parks it at the next boundary
            if (cpu_halted && cpu_step_req)
                cpu_halted <= 1'b0;
            else if (boundary)
                cpu_halted <= 1'b1;
            else if (!halt_req_q)
                cpu_halted <= 1'b0;
`else
            if (boundary)
                cpu_halted <= 1'b1;
            else if (!halt_req_q)
                cpu_halted <= 1'b0;
`endif
        end
    end

endmodule

// File: rtl/debug_bus_responder.sv
// Arbitrates the system memory port between the CPU and debug peek/poke, stalling the CPU via RDY.
// Optional feature macro: DBG_SINGLE_STEP_EN (adds cpu_step_req single-step input).
module debug_bus_responder
    import debug_bus_pkg::*;
#(
    parameter int ADDR_W  = DBG_ADDR_W,
    parameter int DATA_W  = DBG_DATA_W,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic              dbg_we,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    input  logic              cpu_halt_req,
    output logic              cpu_halted,
`ifdef DBG_SINGLE_STEP_EN
    input  logic              cpu_step_req,
`endif
    input  logic              cpu_sync,
    input  logic              cpu_en,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rdy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t                 state;
    logic [ADDR_W-1:0]      addr_q;
    logic [DATA_W-1:0]      wdata_q;
    logic                   we_q;
    logic [LAT_CNT_W-1:0]   lat_cnt;

    debug_halt_ctrl u_halt (
        .clk          (clk),
        .rst          (rst),
        .cpu_halt_req (cpu_halt_req),
        .cpu_sync     (cpu_sync),
        .cpu_en       (cpu_en),
`ifdef DBG_SINGLE_STEP_EN
        .cpu_step_req (cpu_step_req),
`endif
        .cpu_halted   (cpu_halted)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            lat_cnt   <= '0;
            dbg_ack   <= 1'b0;
            dbg_rdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (dbg_req) begin
                        addr_q  <= dbg_addr;
                        wdata_q <= dbg_wdata;
                        we_q    <= dbg_we;
                        state   <= cpu_halted ? S_ISSUE : S_STALL;
                    end
                end
                S_STALL: begin
                    // An abandoned request must never touch memory
                    if (!dbg_req)
                        state <= S_IDLE;
                    else if (!cpu_en)
                        state <= S_ISSUE;
                end
                S_ISSUE: begin
                    lat_cnt <= LAT_CNT_W'(MEM_LAT);
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (lat_cnt == LAT_CNT_W'(1)) begin
                        if (!we_q)
                            dbg_rdata <= mem_rdata;
                        dbg_ack <= 1'b1;
                        state   <= S_ACK;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_CNT_W'(1);
                    end
                end
                S_ACK: begin
                    if (!dbg_req) begin
                        dbg_ack <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_en    = cpu_en;
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        if (state == S_ISSUE || state == S_WAIT) begin
            mem_en    = (state == S_ISSUE);
            mem_we    = (state == S_ISSUE) && we_q;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
        end
    end

    assign cpu_rdata = mem_rdata;
    assign cpu_rdy   = !cpu_halted && (state == S_IDLE);

endmodule

// File: tb/tb_debug_bus_responder.sv
// Randomized bench for debug_bus_responder against a transaction-level memory/halt model.
module tb_debug_bus_responder;
    import debug_bus_pkg::*;

    localparam int AW  = 24;
    localparam int DW  = 8;
    localparam int LAT = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          dbg_req = 1'b0, dbg_we = 1'b0, dbg_ack;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_wdata = '0, dbg_rdata;
    logic          cpu_halt_req = 1'b0, cpu_halted;
    logic          cpu_sync = 1'b0, cpu_en = 1'b0, cpu_we = 1'b0, cpu_rdy;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0, cpu_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    debug_bus_responder #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_we(dbg_we),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .cpu_halt_req(cpu_halt_req), .cpu_halted(cpu_halted),
        .cpu_sync(cpu_sync), .cpu_en(cpu_en), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_we(cpu_we), .cpu_rdata(cpu_rdata), .cpu_rdy(cpu_rdy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Synchronous system RAM with LAT cycles of read latency
    logic [DW-1:0] ram [logic [AW-1:0]];
    logic [DW-1:0] rpipe [LAT];
    always @(posedge clk) begin
        if (mem_en && mem_we) ram[mem_addr] = mem_wdata;
        rpipe[0] <= ram.exists(mem_addr) ? ram[mem_addr] : '0;
        for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_rdata = rpipe[LAT-1];

    // Reference model: expected memory contents and expected halt status
    logic [DW-1:0] exp_mem [logic [AW-1:0]];
    bit            m_halted = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        return exp_mem.exists(a) ? exp_mem[a] : '0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            cpu_en   = m_halted ? 1'b0 : 1'($urandom_range(0, 1));
            cpu_sync = 1'b0;
            cpu_we   = 1'b0;
            cpu_addr = AW'($urandom);
            #1;
            chk("idle_pass_addr", mem_addr, cpu_addr);
            chk("idle_pass_en", mem_en, cpu_en);
            chk("idle_rdy", cpu_rdy, !m_halted);
            tick();
        end
    endtask

    // One debug access; the CPU keeps its bus busy for 'hold' stall edges when running
    task automatic access(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int hold);
        int ack_edge, first_ack, we_pulses;
        bit rdy_seen;
        first_ack = -1; we_pulses = 0; rdy_seen = 1'b0;
        cpu_sync = 1'b0; cpu_we = 1'b0;
        cpu_en   = m_halted ? 1'b0 : 1'b1;
        dbg_req = 1'b1; dbg_addr = a; dbg_wdata = d; dbg_we = we;
        ack_edge = m_halted ? 1 + LAT : hold + 2 + LAT;
        for (int j = 0; j <= ack_edge; j++) begin
            tick();
            if (!m_halted) cpu_en = (j + 1 <= hold);
            cpu_addr = AW'($urandom);
            #1;
            if (mem_we) we_pulses++;
            if (cpu_rdy) rdy_seen = 1'b1;
            if (dbg_ack && first_ack < 0) first_ack = j;
        end
        chk("ack_latency", first_ack, ack_edge);
        chk("rdy_low_in_access", rdy_seen, 1'b0);
        chk("mem_we_pulses", we_pulses, we ? 1 : 0);
        if (we) begin
            exp_mem[a] = d;
            chk("ram_written", ram.exists(a) ? ram[a] : '0, d);
        end else begin
            chk("rd_data", dbg_rdata, exp_rd(a));
            chk("cpu_rdata_pass", cpu_rdata, mem_rdata);
        end
        dbg_req = 1'b0;
        tick();
        chk("ack_fall", dbg_ack, 1'b0);
        chk("rdy_after_ack", cpu_rdy, !m_halted);
    endtask

    task automatic do_halt();
        bit done;
        done = 1'b0;
        cpu_halt_req = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            cpu_en   = 1'($urandom_range(0, 1));
            cpu_sync = ($urandom_range(0, 3) == 0);
            if (i >= 40) begin cpu_en = 1'b1; cpu_sync = 1'b1; end
            cpu_we   = 1'b0;
            cpu_addr = AW'($urandom);
            #1;
            chk("halt_not_early", cpu_halted, 1'b0);
            done = cpu_en && cpu_sync;
            tick();
        end
        chk("halt_set", cpu_halted, 1'b1);
        chk("halt_rdy_low", cpu_rdy, 1'b0);
        m_halted = 1'b1;
        cpu_en = 1'b0; cpu_sync = 1'b0;
    endtask

    task automatic do_resume();
        cpu_halt_req = 1'b0;
        cpu_en = 1'b0; cpu_sync = 1'b0;
        tick();
        chk("resume_rdy_1cyc", cpu_rdy, 1'b0);
        tick();
        chk("resume_halted_clr", cpu_halted, 1'b0);
        chk("resume_rdy_2cyc", cpu_rdy, 1'b1);
        m_halted = 1'b0;
    endtask

    logic [AW-1:0] pool [4];

    initial begin
        bit bad;
        // Reset values
        #1 rst = 1'b1;
        #1;
        chk("rst_ack", dbg_ack, 1'b0);
        chk("rst_rdata", dbg_rdata, '0);
        chk("rst_halted", cpu_halted, 1'b0);
        chk("rst_rdy", cpu_rdy, 1'b1);
        chk("rst_mem_we", mem_we, 1'b0);
        tick();
        rst = 1'b0;
        idle_cycles(4);

        // Running write
        access(1'b1, 24'hFF0010, 8'h5A, 2);
        idle_cycles(2);

        // Halted read
        ram[24'h012345] = 8'hA5;
        exp_mem[24'h012345] = 8'hA5;
        do_halt();
        access(1'b0, 24'h012345, 8'h00, 0);

        // Reset during S_WAIT
        dbg_req = 1'b1; dbg_addr = 24'h012345; dbg_we = 1'b0;
        tick();
        tick();
        chk("pre_rst_rdata", dbg_rdata, 8'hA5);
        rst = 1'b1;
        #1;
        chk("mrst_ack", dbg_ack, 1'b0);
        chk("mrst_rdy", cpu_rdy, 1'b1);
        chk("mrst_halted", cpu_halted, 1'b0);
        chk("mrst_rdata", dbg_rdata, '0);
        dbg_req = 1'b0; cpu_halt_req = 1'b0; m_halted = 1'b0;
        tick();
        rst = 1'b0;
        idle_cycles(2);

        // Abort while the CPU still owns the bus
        cpu_en = 1'b1; cpu_sync = 1'b0;
        dbg_req = 1'b1; dbg_addr = 24'hABCDEF; dbg_we = 1'b1; dbg_wdata = 8'h77;
        tick();
        chk("abort_stall_rdy", cpu_rdy, 1'b0);
        dbg_req = 1'b0;
        tick();
        chk("abort_idle_rdy", cpu_rdy, 1'b1);
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cpu_addr = AW'($urandom);
            #1;
            if (dbg_ack || mem_we || mem_addr !== cpu_addr) bad = 1'b1;
            tick();
        end
        chk("abort_no_access", bad, 1'b0);
        chk("abort_ram_untouched", ram.exists(24'hABCDEF), 1'b0);

        // Halt / resume
        do_halt();
        do_resume();

        // Randomized mix
        for (int i = 0; i < 4; i++) begin
            pool[i] = AW'($urandom);
            ram[pool[i]] = DW'($urandom);
            exp_mem[pool[i]] = ram[pool[i]];
        end
        for (int t = 0; t < 25; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                if (m_halted) do_resume(); else do_halt();
            end
            access(1'($urandom_range(0, 1)), pool[$urandom_range(0, 3)], DW'($urandom),
                   $urandom_range(0, 3));
            idle_cycles($urandom_range(1, 3));
        end
        if (m_halted) do_resume();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/debug_bus_responder.md
# debug_bus_responder

Target-side counterpart of the HPS debug master. It arbitrates the 24-bit system memory port between the 65816 core and debug peek/poke requests, stalls the CPU through RDY while a debug access runs, and completes the `dbg_req`/`dbg_ack` handshake with captured read data. It also turns the master's halt request into an instruction-boundary halt and reports `cpu_halted`. It sits between the CPU core, the debug master and the synchronous system RAM.

## Interface
- `ADDR_W`, default 24: address width.
- `DATA_W`, default 8: data width.
- `MEM_LAT`, default 1: synchronous memory read latency in cycles; legal range 1..4.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `dbg_req` in 1: debug master requests an access; held until `dbg_ack` is seen and the master is done.
- `dbg_addr` in ADDR_W: debug target address.
- `dbg_wdata` in DATA_W: debug write data.
- `dbg_we` in 1: 1 = write, 0 = read.
- `dbg_ack` out 1: access complete; read data valid.
- `dbg_rdata` out DATA_W: registered read data.
- `cpu_halt_req` in 1: level request to halt the CPU.
- `cpu_halted` out 1: CPU is parked at an instruction boundary.
- `cpu_sync` in 1: CPU opcode-fetch cycle marker.
- `cpu_en` in 1: CPU bus cycle active.
- `cpu_addr` in ADDR_W: CPU bus address.
- `cpu_wdata` in DATA_W: CPU write data.
- `cpu_we` in 1: CPU write strobe.
- `cpu_rdata` out DATA_W: read data to the CPU; passthrough of `mem_rdata`.
- `cpu_rdy` out 1: RDY to the core; low stalls it.
- `mem_en` out 1: memory port enable.
- `mem_we` out 1: memory port write strobe.
- `mem_addr` out ADDR_W: memory port address.
- `mem_wdata` out DATA_W: memory port write data.
- `mem_rdata` in DATA_W: memory port read data.

## Operation
- **States:**
  - `S_IDLE`: CPU owns the memory port.
  - `S_STALL`: RDY held low, waiting for the CPU to quiesce.
  - `S_ISSUE`: debug drives the memory port.
  - `S_WAIT`: waiting out the memory read latency.
  - `S_ACK`: handshake completion.
- **`S_IDLE`:**
  - On `dbg_req`, latch `dbg_addr`, `dbg_wdata` and `dbg_we`.
  - If `cpu_halted`=1, go to `S_ISSUE`; otherwise go to `S_STALL`.
- **`S_STALL`:**
  - `cpu_rdy`=0.
  - When `cpu_en`=0 is sampled, go to `S_ISSUE`.
  - If `dbg_req` falls before the issue, return to `S_IDLE`; no memory access occurs.
- **`S_ISSUE`:** exactly one cycle.
  - `mem_en`=1, `mem_we`=latched `we`, and latched address/data on the memory port.
  - Go to `S_WAIT` with the counter loaded to `MEM_LAT`.
- **`S_WAIT`:**
  - Lasts exactly `MEM_LAT` cycles.
  - On the last cycle, for reads only, `dbg_rdata` <= `mem_rdata`.
  - Then go to `S_ACK`.
- **`S_ACK`:**
  - `dbg_ack`=1 until `dbg_req` is sampled low, then go to `S_IDLE`.
  - `dbg_rdata` holds its value until the next read capture.
- **Memory port muxing:**
  - The port is driven by debug only in `S_ISSUE`/`S_WAIT`.
  - Otherwise it is a combinational passthrough of the `cpu_*` signals.
- **Halt logic:**
  - `cpu_halted` is set on the edge where `cpu_halt_req`, `cpu_sync` and `cpu_en` are all 1.
  - `cpu_halted` is cleared on the edge after `cpu_halt_req` is sampled 0.
- **RDY:** `cpu_rdy` = !`cpu_halted` && state ∈ {`S_IDLE`}.
- **Simultaneous events:**
  - Halt and debug events are handled independently.
  - A resume during a debug access leaves RDY low until the return to `S_IDLE`.
  - A halt request arriving during `S_STALL` sets `cpu_halted` only at a later `cpu_sync`.
- **Mid-operation reset:** everything returns to reset values immediately. An in-flight write may or may not have reached memory.

## Timing
- **Reset values:**
  - state = `S_IDLE`.
  - `dbg_ack`=0, `dbg_rdata`=0, `cpu_halted`=0.
  - Debug-side memory strobes are 0.
  - `cpu_rdy`=1.
- **Latency, CPU halted:** `dbg_req` is sampled in cycle 0.
  - Cycle 1: `S_ISSUE`.
  - Cycles 2..1+`MEM_LAT`: `S_WAIT`.
  - `dbg_ack` is first high in cycle 2+`MEM_LAT`.
- **Latency, CPU running:** add the `S_STALL` length, at least 1 cycle.
- `dbg_ack` falls in the cycle after `dbg_req` is sampled low.
- A new request is accepted no sooner than one cycle in `S_IDLE`.
- `mem_we` is a single-cycle pulse, and never coincides with CPU port ownership.

## Configuration
- **`DBG_SINGLE_STEP_EN` defined:**
  - Adds input `cpu_step_req` (1-cycle pulse).
  - While halted, a pulse clears `cpu_halted` and raises `cpu_rdy`.
  - The CPU runs until the next `cpu_sync`+`cpu_en`; `cpu_halted` is set again on that edge, after exactly one instruction.
  - A step pulse while not halted, or while a step is in progress, is ignored.
- **Undefined:** no port, and halt behaviour is as above.

## Structure
- **Package `debug_bus_pkg`:**
  - State enum.
  - `DBG_ADDR_W`/`DBG_DATA_W` constants.
  - Command-type constants shared with the debug master (0 = read, 1 = write, 2 = halt, 3 = resume).
- **Sub-module `debug_halt_ctrl`:**
  - Contains the halt/resume/step flag logic.
  - Inputs: `cpu_halt_req`, `cpu_sync`, `cpu_en` and `cpu_step_req`.
  - Output: `cpu_halted`.
- The top level holds the access FSM, latency counter and port mux.

## Test plan
- **Halted read:**
  - Stimulus: RAM[0x012345]=0xA5, `cpu_halted`=1, read request for 0x012345.
  - Response: `dbg_ack` high in cycle 3 (`MEM_LAT`=1), `dbg_rdata`=0xA5, CPU port untouched.
- **Running write:**
  - Stimulus: CPU issuing cycles; write 0x5A to 0xFF0010.
  - Response: `cpu_rdy` low until ack release; single `mem_we` pulse; RAM[0xFF0010]=0x5A; CPU resumes with no lost cycle.
- **Halt/resume:**
  - Stimulus: assert `cpu_halt_req` mid-instruction.
  - Response: `cpu_halted` rises at the next `cpu_sync` and `cpu_rdy`=0; dropping the request gives `cpu_rdy`=1 two cycles later.
- **Abort in stall:**
  - Stimulus: `dbg_req` deasserted while `cpu_en` is still high.
  - Response: no `mem_en` from debug; back to `S_IDLE`; `dbg_ack` never rises.
- **Reset mid-access:**
  - Stimulus: `rst` pulsed during `S_WAIT`.
  - Response: `dbg_ack`=0, `cpu_rdy`=1, `cpu_halted`=0, `dbg_rdata`=0 asynchronously.
- **Step, with `DBG_SINGLE_STEP_EN`:**
  - Stimulus: while halted, pulse `cpu_step_req`.
  - Response: exactly one `cpu_sync` executes, then `cpu_halted`=1 again.
